// File: rtl/linear_regression_sequencer.sv
// linear_regression_sequencer
// Computes y = INTERCEPT + SLOPE0*x0 + SLOPE1*x1 + SLOPE2*x2 (unsigned) using one
// shared DW x DW multiplier, one product per cycle over three MUL states.
// Optional feature macro: LINREG_SATURATE_EN -- when defined, an accumulation
// carry-out clamps the accumulator to all ones until the result is delivered;
// otherwise the accumulator wraps. ovf is set on carry-out in both builds.
module linear_regression_sequencer #(
    parameter int DW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic [DW-1:0]     cfg_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     x0,
    input  logic [DW-1:0]     x1,
    input  logic [DW-1:0]     x2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*DW-1:0]   y,
    output logic              busy,
    output logic              ovf
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL0 = 3'd1,
        MUL1 = 3'd2,
        MUL2 = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    // Coefficient bank: index 0 = INTERCEPT, 1..3 = SLOPE0..SLOPE2
    logic [DW-1:0]       r_coef [4];
    logic [3:0]          w_coef_we;
    logic [DW-1:0]       r_x [3];
    logic [2*DW-1:0]     r_acc;
    logic                r_ovf;

    logic                w_handshake;
    logic [DW-1:0]       w_intercept_eff;
    logic [DW-1:0]       w_mul_a;
    logic [DW-1:0]       w_mul_b;
    logic [2*DW-1:0]     w_prod;
    logic [2*DW:0]       w_sum;
    logic                w_carry;

    assign w_handshake = in_valid && (r_state == IDLE);

    // A coincident INTERCEPT write must be seen by the accumulator preload
    assign w_intercept_eff = (cfg_we && cfg_addr == 2'd0) ? cfg_data : r_coef[0];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_coef
            assign w_coef_we[gi] = cfg_we && (r_state == IDLE) && (cfg_addr == 2'(gi));

            // Coefficient register: writable only while idle
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_coef[gi] <= '0;
                end else if (w_coef_we[gi]) begin
                    r_coef[gi] <= cfg_data;
                end
            end
        end

        for (gi = 0; gi < 3; gi++) begin : g_feat
            // Feature latch captured at the input handshake
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_x[gi] <= '0;
                end else if (w_handshake) begin
                    r_x[gi] <= (gi == 0) ? x0 : ((gi == 1) ? x1 : x2);
                end
            end
        end
    endgenerate

    // Operand select for the single shared multiplier
    always_comb begin
        w_mul_a = r_coef[1];
        w_mul_b = r_x[0];
        case (r_state)
            MUL1: begin
                w_mul_a = r_coef[2];
                w_mul_b = r_x[1];
            end
            MUL2: begin
                w_mul_a = r_coef[3];
                w_mul_b = r_x[2];
            end
            default: begin
                w_mul_a = r_coef[1];
                w_mul_b = r_x[0];
            end
        endcase
    end

    assign w_prod  = w_mul_a * w_mul_b;
    assign w_sum   = {1'b0, r_acc} + {1'b0, w_prod};
    assign w_carry = w_sum[2*DW];

    // Accumulator and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (w_handshake) begin
            r_acc <= {{DW{1'b0}}, w_intercept_eff};
            r_ovf <= 1'b0;
        end else if (r_state == MUL0 || r_state == MUL1 || r_state == MUL2) begin
            r_ovf <= r_ovf | w_carry;
`ifdef LINREG_SATURATE_EN
            // Once clamped, stay clamped until the result has been taken
            if (w_carry || r_ovf) begin
                r_acc <= '1;
            end else begin
                r_acc <= w_sum[2*DW-1:0];
            end
`else
            r_acc <= w_sum[2*DW-1:0];
`endif
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_next = MUL0;
            MUL0:    w_state_next = MUL1;
            MUL1:    w_state_next = MUL2;
            MUL2:    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign y         = r_acc;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_linear_regression_sequencer.sv
// Testbench for linear_regression_sequencer: directed vectors, expected results
// pushed into a scoreboard queue and checked by an independent monitor.
module tb_linear_regression_sequencer;

    localparam int DW = 16;

    logic              clk;
    logic              rst;
    logic              cfg_we;
    logic [1:0]        cfg_addr;
    logic [DW-1:0]     cfg_data;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     x0, x1, x2;
    logic              out_valid;
    logic              out_ready;
    logic [2*DW-1:0]   y;
    logic              busy;
    logic              ovf;

    int checks = 0;
    int errors = 0;

    // Scoreboard entries are {ovf, y}
    logic [2*DW:0]     exp_q [$];
    logic [2*DW:0]     mon_exp;

`ifdef LINREG_SATURATE_EN
    localparam logic [2*DW-1:0] OVF_Y = 32'hFFFF_FFFF;
`else
    localparam logic [2*DW-1:0] OVF_Y = 32'hFFFA_0003;
`endif

    linear_regression_sequencer #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x0        (x0),
        .x1        (x1),
        .x2        (x2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .busy      (busy),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare every accepted result against the scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got y=%h ovf=%b, required no result", y, ovf);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({ovf, y} !== mon_exp) begin
                    errors++;
                    $display("FAIL result: got y=%h ovf=%b, required y=%h ovf=%b",
                             y, ovf, mon_exp[2*DW-1:0], mon_exp[2*DW]);
                end else begin
                    $display("result y=%h ovf=%b ok", y, ovf);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic write_cfg(input logic [1:0] addr, input logic [DW-1:0] data);
        cfg_addr = addr;
        cfg_data = data;
        cfg_we   = 1'b1;
        tick();
        cfg_we   = 1'b0;
        $display("cfg write addr=%0d data=%h", addr, data);
    endtask

    task automatic set_coefs(input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                             input logic [DW-1:0] c2, input logic [DW-1:0] c3);
        write_cfg(2'd0, c0);
        write_cfg(2'd1, c1);
        write_cfg(2'd2, c2);
        write_cfg(2'd3, c3);
    endtask

    // Present one sample and return in the cycle after the handshake (MUL0)
    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
        int n;
        x0 = a; x1 = b; x2 = c;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0, required 1");
        end
        tick();
        in_valid = 1'b0;
        $display("sample x=(%h,%h,%h)", a, b, c);
    endtask

    // Wait for out_valid (bounded), then let the accepting edge pass
    task automatic wait_result();
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: got out_valid=0, required 1");
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; x0 = '0; x1 = '0; x2 = '0; out_ready = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("reset_in_ready", in_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_y", y, 0);
        chk("reset_ovf", ovf, 0);

        // Nominal with latency check: handshake at T, out_valid at T+4
        set_coefs(10, 2, 3, 4);
        exp_q.push_back({1'b0, 32'd30});
        send(1, 2, 3);
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("lat_out_valid_T+%0d", i), out_valid, 0);
            chk($sformatf("lat_busy_T+%0d", i), busy, 1);
            chk($sformatf("lat_in_ready_T+%0d", i), in_ready, 0);
            tick();
        end
        chk("lat_out_valid_T+4", out_valid, 1);
        tick();
        chk("post_done_out_valid", out_valid, 0);
        chk("post_done_in_ready", in_ready, 1);

        // Backpressure: 5 cycles held in DONE with y stable
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 32'd30});
        send(1, 2, 3);
        tick(); tick(); tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_y_stable", y, 30);
            chk("bp_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_out_valid", out_valid, 0);
        chk("bp_release_in_ready", in_ready, 1);

        // Coefficient write while busy is ignored
        exp_q.push_back({1'b0, 32'd30});
        send(1, 2, 3);
        tick();
        cfg_addr = 2'd1; cfg_data = 16'd100; cfg_we = 1'b1;
        chk("busy_write_busy", busy, 1);
        tick();
        cfg_we = 1'b0;
        wait_result();
        exp_q.push_back({1'b0, 32'd30});
        send(1, 2, 3);
        wait_result();

        // Coincident INTERCEPT write and handshake: new value used (20+2+6+12)
        exp_q.push_back({1'b0, 32'd40});
        cfg_addr = 2'd0; cfg_data = 16'd20; cfg_we = 1'b1;
        send(1, 2, 3);
        cfg_we = 1'b0;
        wait_result();

        // Overflow
        set_coefs(16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        exp_q.push_back({1'b1, OVF_Y});
        send(16'hFFFF, 16'hFFFF, 16'hFFFF);
        wait_result();
        chk("ovf_sticky_idle", ovf, 1);

        // ovf cleared by the next handshake
        set_coefs(10, 2, 3, 4);
        exp_q.push_back({1'b0, 32'd30});
        send(1, 2, 3);
        chk("ovf_cleared_after_hs", ovf, 0);
        wait_result();

        // Back-to-back with in_valid held: results at T+4 and T+9
        exp_q.push_back({1'b0, 32'd30});
        exp_q.push_back({1'b0, 32'd28});
        send(1, 2, 3);
        in_valid = 1'b1;
        x0 = 2; x1 = 2; x2 = 2;
        for (int i = 1; i <= 10; i++) begin
            chk($sformatf("b2b_out_valid_T+%0d", i), out_valid, (i == 4 || i == 9) ? 1 : 0);
            if (i == 5) chk("b2b_in_ready_T+5", in_ready, 1);
            tick();
            if (i == 5) in_valid = 1'b0;
        end

        // Reset in MUL1 discards the result and clears coefficients
        send(1, 2, 3);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_y", y, 0);
        for (int i = 0; i < 8; i++) begin
            chk("midrst_no_out_valid", out_valid, 0);
            tick();
        end
        exp_q.push_back({1'b0, 32'd0});
        send(5, 5, 5);
        wait_result();

        tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
